// File: rtl/fpra_pkg.sv
// Shared definitions for the FP32 row accumulator: FP32 field layout,
// controller state encodings and a leading-zero counter used by FP_Adder.
package fpra_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } fpra_state_t;

    // Leading zeros of a 27-bit value; returns 27 for an all-zero input.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_row_accumulator_fp_adder.sv
// FP_Adder: combinational IEEE-754 single-precision adder.
// Round to nearest-even, subnormal inputs/outputs, Inf/NaN propagation,
// overflow to signed infinity, exact cancellation gives +0.
module FP_Adder
    import fpra_pkg::*;
(
    output logic [31:0] out,
    input  logic [31:0] a,
    input  logic [31:0] b
);

    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [4:0]  dsh, lz, lsh;
    logic [26:0] xa, ya, ysh, mask, ys, n;
    logic [27:0] s;
    logic [9:0]  e;
    logic [24:0] r;
    logic        eff_sub, up, a_nan, b_nan, a_inf, b_inf;

    // Align the smaller operand, add or subtract, normalise and round
    always_comb begin
        // NOTE: every variable gets a value before any branch reads or skips it, so no latch is inferred.
        n   = '0;
        lz  = '0;
        lsh = '0;
        out = FP32_ZERO;

        // NOTE: blocking assignments here because each step feeds the next within one evaluation.
        a_nan = (a[EXP_MSB:EXP_LSB] == 8'hFF) && (a[MAN_MSB:0] != '0);
        b_nan = (b[EXP_MSB:EXP_LSB] == 8'hFF) && (b[MAN_MSB:0] != '0);
        a_inf = (a[EXP_MSB:EXP_LSB] == 8'hFF) && (a[MAN_MSB:0] == '0);
        b_inf = (b[EXP_MSB:EXP_LSB] == 8'hFF) && (b[MAN_MSB:0] == '0);

        // x carries the larger magnitude so the difference is never negative
        if (a[EXP_MSB:0] >= b[EXP_MSB:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end

        // Subnormals use exponent 1 with a zero hidden bit
        ex = (x[EXP_MSB:EXP_LSB] == 8'd0) ? 8'd1 : x[EXP_MSB:EXP_LSB];
        ey = (y[EXP_MSB:EXP_LSB] == 8'd0) ? 8'd1 : y[EXP_MSB:EXP_LSB];
        xa = {(x[EXP_MSB:EXP_LSB] != 8'd0), x[MAN_MSB:0], 3'b000};
        ya = {(y[EXP_MSB:EXP_LSB] != 8'd0), y[MAN_MSB:0], 3'b000};

        // Right-align y; bits shifted out collapse into the sticky bit
        d    = ex - ey;
        dsh  = (d > 8'd26) ? 5'd27 : d[4:0];
        ysh  = ya >> dsh;
        mask = (27'd1 << dsh) - 27'd1;
        ys   = {ysh[26:1], ysh[0] | (|(ya & mask))};

        eff_sub = x[SIGN_BIT] ^ y[SIGN_BIT];
        s = eff_sub ? ({1'b0, xa} - {1'b0, ys}) : ({1'b0, xa} + {1'b0, ys});
        e = {2'b00, ex};

        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            lz = lzc27(s[26:0]);
            if ({5'd0, lz} < e) begin
                lsh = lz;
                e   = e - {5'd0, lz};
            end else begin
                // Result underflows into the subnormal range
                lsh = 5'(e - 10'd1);
                e   = 10'd0;
            end
            n = s[26:0] << lsh;
        end

        up = n[2] & (n[1] | n[0] | n[3]);
        r  = {1'b0, n[26:3]} + {24'd0, up};
        if (r[24]) begin
            r = r >> 1;
            e = e + 10'd1;
        end else if ((e == 10'd0) && r[23]) begin
            e = 10'd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[SIGN_BIT] != b[SIGN_BIT])))
            out = FP32_QNAN;
        else if (a_inf)
            out = a;
        else if (b_inf)
            out = b;
        else if (s == 28'd0)
            out = {~eff_sub & x[SIGN_BIT], 31'd0};
        else if (e >= 10'd255)
            out = {x[SIGN_BIT], 8'hFF, 23'd0};
        else
            out = {x[SIGN_BIT], e[7:0], r[22:0]};
    end

endmodule

// File: rtl/fp_row_accumulator.sv
// fp_row_accumulator: reduces consecutive same-row FP32 products into one
// row sum per run and emits {row, sum} on row change or in_last.
// Optional element count output enabled by defining FPRA_NNZ_COUNT_EN.
module fp_row_accumulator
    import fpra_pkg::*;
#(
    parameter int ROW_W = 16
`ifdef FPRA_NNZ_COUNT_EN
   ,parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    input  logic [ROW_W-1:0] in_row_idx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [ROW_W-1:0] out_row_idx
`ifdef FPRA_NNZ_COUNT_EN
   ,output logic [CNT_W-1:0] out_nnz
`endif
);

    fpra_state_t      state;
    logic [31:0]      acc, add_sum, pend_val;
    logic [ROW_W-1:0] cur_row, pend_row;
    logic             pend_v, pend_last, accept, same_row;

    assign in_ready = rst && (state != EMIT);
    assign accept   = in_valid && in_ready;
    assign same_row = (in_row_idx == cur_row);

    FP_Adder u_adder (
        .out (add_sum),
        .a   (acc),
        .b   (in_value)
    );

    // Row-merge controller with registered emit outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: datapath registers are reset too, so a half-built row or parked element never leaks out after reset.
            state       <= IDLE;
            acc         <= FP32_ZERO;
            cur_row     <= '0;
            pend_v      <= 1'b0;
            pend_val    <= FP32_ZERO;
            pend_row    <= '0;
            pend_last   <= 1'b0;
            out_valid   <= 1'b0;
            out_sum     <= FP32_ZERO;
            out_row_idx <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    // First element loads directly so -0.0 survives unchanged
                    acc     <= in_value;
                    cur_row <= in_row_idx;
                    if (in_last) begin
                        state       <= EMIT;
                        out_valid   <= 1'b1;
                        out_sum     <= in_value;
                        out_row_idx <= in_row_idx;
                    end else begin
                        state <= ACCUM;
                    end
                end
                ACCUM: if (accept) begin
                    if (same_row) begin
                        acc <= add_sum;
                        if (in_last) begin
                            state       <= EMIT;
                            out_valid   <= 1'b1;
                            out_sum     <= add_sum;
                            out_row_idx <= cur_row;
                        end
                    end else begin
                        // Park the new row's element until the old row drains
                        pend_v      <= 1'b1;
                        pend_val    <= in_value;
                        pend_row    <= in_row_idx;
                        pend_last   <= in_last;
                        state       <= EMIT;
                        out_valid   <= 1'b1;
                        out_sum     <= acc;
                        out_row_idx <= cur_row;
                    end
                end
                EMIT: if (out_ready) begin
                    if (pend_v) begin
                        acc     <= pend_val;
                        cur_row <= pend_row;
                        pend_v  <= 1'b0;
                        if (pend_last) begin
                            out_sum     <= pend_val;
                            out_row_idx <= pend_row;
                        end else begin
                            state     <= ACCUM;
                            out_valid <= 1'b0;
                        end
                    end else begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPRA_NNZ_COUNT_EN
    logic [CNT_W-1:0] cnt, cnt_inc;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // Count merged elements per row and capture the count with the emitted sum
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            out_nnz <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt <= CNT_W'(1);
                    if (in_last) out_nnz <= CNT_W'(1);
                end
                ACCUM: if (accept) begin
                    if (same_row) begin
                        cnt <= cnt_inc;
                        if (in_last) out_nnz <= cnt_inc;
                    end else begin
                        out_nnz <= cnt;
                    end
                end
                EMIT: if (out_ready && pend_v) begin
                    cnt <= CNT_W'(1);
                    if (pend_last) out_nnz <= CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fp_row_accumulator.sv
// Directed bench for fp_row_accumulator with hand-computed FP32 results.
module tb_fp_row_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [15:0] in_row_idx;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [15:0] out_row_idx;
`ifdef FPRA_NNZ_COUNT_EN
    logic [7:0]  out_nnz;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_row_accumulator #(
        .ROW_W (16)
`ifdef FPRA_NNZ_COUNT_EN
       ,.CNT_W (8)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_row_idx  (in_row_idx),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_row_idx (out_row_idx)
`ifdef FPRA_NNZ_COUNT_EN
       ,.out_nnz     (out_nnz)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one element and hold it until it transfers (bounded wait)
    task automatic send(input logic [31:0] v, input logic [15:0] r, input logic l);
        int n = 0;
        in_valid   = 1'b1;
        in_value   = v;
        in_row_idx = r;
        in_last    = l;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready stayed %0b, required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for out_valid
    task automatic wait_out(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout out_valid=%0b, required 1", name, out_valid);
        end
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_value = '0; in_row_idx = '0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake out_valid=%0b in_ready=%0b, required 0 0", out_valid, in_ready);
        end
        checks++;
        if (out_sum !== 32'h0 || out_row_idx !== 16'h0) begin
            failures++;
            $display("FAIL reset_data out_sum=%h row=%0d, required 00000000 0", out_sum, out_row_idx);
        end
`ifdef FPRA_NNZ_COUNT_EN
        checks++;
        if (out_nnz !== 8'd0) begin
            failures++;
            $display("FAIL reset_nnz out_nnz=%0d, required 0", out_nnz);
        end
`endif
        rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready=%0b, required 1", in_ready);
        end
    endtask

    // T1: 2.0 + 0.5 on row 3
    task automatic test_merge();
        send(32'h4000_0000, 16'd3, 1'b0);
        send(32'h3F00_0000, 16'd3, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL merge_latency out_valid=%0b, required 1", out_valid);
        end
        wait_out("merge");
        checks++;
        if (out_sum !== 32'h4020_0000 || out_row_idx !== 16'd3) begin
            failures++;
            $display("FAIL merge_sum got=%h row=%0d, required 40200000 row 3", out_sum, out_row_idx);
        end
`ifdef FPRA_NNZ_COUNT_EN
        checks++;
        if (out_nnz !== 8'd2) begin
            failures++;
            $display("FAIL merge_nnz got=%0d, required 2", out_nnz);
        end
`endif
        take_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL merge_drain out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
    endtask

    // T2: row change parks the new element, then it emits on its own
    task automatic test_row_change();
        send(32'h3F80_0000, 16'd1, 1'b0);
        send(32'h4000_0000, 16'd2, 1'b1);
        wait_out("rowchg_first");
        checks++;
        if (out_sum !== 32'h3F80_0000 || out_row_idx !== 16'd1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rowchg_first got=%h row=%0d in_ready=%0b, required 3f800000 row 1 in_ready 0",
                     out_sum, out_row_idx, in_ready);
        end
        take_out();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h4000_0000 || out_row_idx !== 16'd2) begin
            failures++;
            $display("FAIL rowchg_second valid=%0b got=%h row=%0d, required 1 40000000 row 2",
                     out_valid, out_sum, out_row_idx);
        end
`ifdef FPRA_NNZ_COUNT_EN
        checks++;
        if (out_nnz !== 8'd1) begin
            failures++;
            $display("FAIL rowchg_nnz got=%0d, required 1", out_nnz);
        end
`endif
        take_out();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rowchg_drain out_valid=%0b, required 0", out_valid);
        end
    endtask

    // T3: held output under backpressure, no input accepted while emitting
    task automatic test_backpressure();
        send(32'h40A0_0000, 16'd5, 1'b1);
        wait_out("bp");
        in_valid = 1'b1; in_value = 32'h3F80_0000; in_row_idx = 16'd5; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 32'h40A0_0000 || out_row_idx !== 16'd5) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d in_ready=%0b valid=%0b got=%h row=%0d, required 0 1 40a00000 row 5",
                         i, in_ready, out_valid, out_sum, out_row_idx);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_single_transfer out_valid=%0b, required 0", out_valid);
        end
        step();
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h3F80_0000 || out_row_idx !== 16'd5) begin
            failures++;
            $display("FAIL bp_separate_sum valid=%0b got=%h row=%0d, required 1 3f800000 row 5",
                     out_valid, out_sum, out_row_idx);
        end
        take_out();
    endtask

    // T4: exact cancellation gives +0
    task automatic test_cancel();
        send(32'h4040_0000, 16'd7, 1'b0);
        send(32'hC040_0000, 16'd7, 1'b1);
        wait_out("cancel");
        checks++;
        if (out_sum !== 32'h0000_0000 || out_row_idx !== 16'd7) begin
            failures++;
            $display("FAIL cancel_sum got=%h row=%0d, required 00000000 row 7", out_sum, out_row_idx);
        end
        take_out();
    endtask

    // T5: reset while a row is emitting with a parked element
    task automatic test_reset_mid();
        send(32'h3F80_0000, 16'd4, 1'b0);
        send(32'h4000_0000, 16'd6, 1'b0);
        wait_out("rstmid_pre");
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_cleared out_valid=%0b in_ready=%0b, required 0 0", out_valid, in_ready);
        end
        rst = 1'b1;
        step();
        send(32'h3F80_0000, 16'd9, 1'b1);
        wait_out("rstmid_post");
        checks++;
        if (out_sum !== 32'h3F80_0000 || out_row_idx !== 16'd9) begin
            failures++;
            $display("FAIL rstmid_sum got=%h row=%0d, required 3f800000 row 9", out_sum, out_row_idx);
        end
        take_out();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_stale cycle=%0d out_valid=%0b got=%h, required 0", i, out_valid, out_sum);
            end
            step();
        end
    endtask

    // T6: 300 x 1.0 on one row; count saturates at 255
    task automatic test_saturation();
        for (int i = 0; i < 300; i++) send(32'h3F80_0000, 16'd11, (i == 299));
        wait_out("sat");
        checks++;
        if (out_sum !== 32'h4396_0000 || out_row_idx !== 16'd11) begin
            failures++;
            $display("FAIL sat_sum got=%h row=%0d, required 43960000 row 11", out_sum, out_row_idx);
        end
`ifdef FPRA_NNZ_COUNT_EN
        checks++;
        if (out_nnz !== 8'd255) begin
            failures++;
            $display("FAIL sat_nnz got=%0d, required 255", out_nnz);
        end
`endif
        take_out();
    endtask

    // Equal rows split by an emit, -0.0 passthrough, Inf/NaN propagation
    task automatic test_back_to_back();
        send(32'h3F80_0000, 16'd3, 1'b1);
        wait_out("b2b_a");
        checks++;
        if (out_sum !== 32'h3F80_0000 || out_row_idx !== 16'd3) begin
            failures++;
            $display("FAIL b2b_first got=%h row=%0d, required 3f800000 row 3", out_sum, out_row_idx);
        end
        take_out();
        send(32'h4000_0000, 16'd3, 1'b1);
        wait_out("b2b_b");
        checks++;
        if (out_sum !== 32'h4000_0000 || out_row_idx !== 16'd3) begin
            failures++;
            $display("FAIL b2b_second got=%h row=%0d, required 40000000 row 3", out_sum, out_row_idx);
        end
        take_out();
        send(32'h8000_0000, 16'd2, 1'b1);
        wait_out("negzero");
        checks++;
        if (out_sum !== 32'h8000_0000 || out_row_idx !== 16'd2) begin
            failures++;
            $display("FAIL negzero got=%h row=%0d, required 80000000 row 2", out_sum, out_row_idx);
        end
        take_out();
        send(32'h7F80_0000, 16'd8, 1'b0);
        send(32'h3F80_0000, 16'd8, 1'b1);
        wait_out("inf");
        checks++;
        if (out_sum !== 32'h7F80_0000 || out_row_idx !== 16'd8) begin
            failures++;
            $display("FAIL inf_prop got=%h row=%0d, required 7f800000 row 8", out_sum, out_row_idx);
        end
        take_out();
        send(32'h7F80_0000, 16'd8, 1'b0);
        send(32'hFF80_0000, 16'd8, 1'b1);
        wait_out("nan");
        checks++;
        if (out_sum[30:23] !== 8'hFF || out_sum[22:0] === 23'd0) begin
            failures++;
            $display("FAIL nan_prop got=%h, required a NaN (exp ff, mantissa nonzero)", out_sum);
        end
        take_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_merge();
        test_row_change();
        test_backpressure();
        test_cancel();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
